// File: rtl/aes_round_sequencer_pkg.sv
// aes_seq_pkg: shared types and constants for the AES-128 round sequencer.
//   seq_state_e : sequencer FSM states (IDLE, LOAD, ROUND, DONE)
//   ROUND_MAX   : last AES-128 round number (10)
//   RCON_INIT   : first round constant of the key schedule
//   xtime()     : multiply-by-x in GF(2^8) reduced by 8'h1b
package aes_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam logic [3:0] ROUND_MAX = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: plaintext/key request and ciphertext response
// handshakes of the round sequencer.
//   pt_i, key_i, valid_i / ready_o     : block request (byte 0 in bits 127:120)
//   ct_o, ct_valid_o / ct_ready_i      : ciphertext response
// Modports: master = requester/consumer side, slave = sequencer side.
interface aes_round_sequencer_if;
    logic [127:0] pt_i;
    logic [127:0] key_i;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] ct_o;
    logic         ct_valid_o;
    logic         ct_ready_i;

    modport master (
        output pt_i, key_i, valid_i, ct_ready_i,
        input  ready_o, ct_o, ct_valid_o
    );

    modport slave (
        input  pt_i, key_i, valid_i, ct_ready_i,
        output ready_o, ct_o, ct_valid_o
    );
endinterface

// File: rtl/aes_round_sequencer_key_expand_step.sv
// aes_key_expand_step: one AES-128 key-schedule step, combinational.
//   k_i    : current round key (word 0 in bits 127:96)
//   rcon_i : round constant for this step
//   k_o    : next round key
module aes_key_expand_step (
    input  logic [127:0] k_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] k_o
);

    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] t_w;
    logic [31:0] w0, w1, w2, w3;

    assign rot_w = {k_i[23:0], k_i[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox_lut u_sbox (
            .a_i   (rot_w[8*g +: 8]),
            .dec_i (1'b0),
            .s_o   (sub_w[8*g +: 8])
        );
    end

    assign t_w = sub_w ^ {rcon_i, 24'h0};
    assign w0  = k_i[127:96] ^ t_w;
    assign w1  = k_i[95:64]  ^ w0;
    assign w2  = k_i[63:32]  ^ w1;
    assign w3  = k_i[31:0]   ^ w2;
    assign k_o = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_sbox_lut.sv
// aes_sbox_lut: combinational AES S-box (dec_i=0) or inverse S-box (dec_i=1).
//   a_i   : input byte
//   dec_i : select inverse substitution
//   s_o   : substituted byte
// The table is generated from the GF(2^8) inverse and the affine map, which
// synthesis folds into a 256-entry lookup.
module aes_sbox_lut
    import aes_seq_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic       dec_i,
    output logic [7:0] s_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
        logic [15:0] xx;
        xx = {x, x} << n;
        return xx[15:8];
    endfunction

    logic [7:0] inv_fwd;
    logic [7:0] fwd_s;
    logic [7:0] pre_inv;
    logic [7:0] inv_s;

    always_comb begin
        inv_fwd = gf_inv(a_i);
        fwd_s   = inv_fwd ^ rotl(inv_fwd, 1) ^ rotl(inv_fwd, 2)
                ^ rotl(inv_fwd, 3) ^ rotl(inv_fwd, 4) ^ 8'h63;
        pre_inv = rotl(a_i, 1) ^ rotl(a_i, 3) ^ rotl(a_i, 6) ^ 8'h05;
        inv_s   = gf_inv(pre_inv);
        s_o     = dec_i ? inv_s : fwd_s;
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control and on-the-fly key expansion for a single-round
// AES-128 encrypt datapath. Accepts one plaintext/key pair, drives the datapath
// through rounds 0..10 (one per clock) and returns its final state as ciphertext.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : pt/key request handshake and ciphertext handshake
//   trig_o             : capture trigger, high during LOAD and all ROUND cycles
//   round1, load_i1    : round-0 strobe to datapath (round1 always 0)
//   round2, load_i2    : rounds 1..10 strobe to datapath
//   round_max          : constant 10
//   key_i1, key_i2     : round keys for the two strobes
//   data_i             : initial state (plaintext) during LOAD
//   data_o             : registered datapath state, forwarded as ct_o
// Parameter IDLE_ZERO: 1 = key_i1/key_i2/data_i read 0 outside their active
// cycle, 0 = they hold their last values.
// Macro AES_SEQ_TRIGGER_EN: when defined, trig_o is a flop; otherwise tied 0.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_sequencer_if.slave  bus,
    output logic                  trig_o,
    output logic [3:0]            round1,
    output logic [3:0]            round2,
    output logic [3:0]            round_max,
    output logic                  load_i1,
    output logic                  load_i2,
    output logic [127:0]          key_i1,
    output logic [127:0]          key_i2,
    output logic [127:0]          data_i,
    input  logic [127:0]          data_o
);

    seq_state_e   state_q;
    logic [127:0] pt_q;
    logic [127:0] rk_q;
    logic [127:0] rk_d;
    logic [7:0]   rcon_q;
    logic [3:0]   rcnt_q;
    logic         ready_q;
    logic         ct_valid_q;
    logic         load1_q;
    logic         load2_q;
    logic [3:0]   round2_q;
    logic [127:0] key1_q;
    logic [127:0] key2_q;

    aes_key_expand_step u_key_step (
        .k_i    (rk_q),
        .rcon_i (rcon_q),
        .k_o    (rk_d)
    );

    // Output registers are loaded with the value they must show in the state
    // being entered, so every strobe lines up with its state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pt_q       <= '0;
            rk_q       <= '0;
            rcon_q     <= RCON_INIT;
            rcnt_q     <= '0;
            ready_q    <= 1'b1;
            ct_valid_q <= 1'b0;
            load1_q    <= 1'b0;
            load2_q    <= 1'b0;
            round2_q   <= '0;
            key1_q     <= '0;
            key2_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        pt_q    <= bus.pt_i;
                        rk_q    <= bus.key_i;
                        rcon_q  <= RCON_INIT;
                        key1_q  <= bus.key_i;
                        load1_q <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    rk_q     <= rk_d;
                    rcon_q   <= xtime(rcon_q);
                    rcnt_q   <= 4'd1;
                    load1_q  <= 1'b0;
                    load2_q  <= 1'b1;
                    round2_q <= 4'd1;
                    key2_q   <= rk_d;
                    if (IDLE_ZERO) key1_q <= '0;
                    state_q  <= ROUND;
                end
                ROUND: begin
                    rk_q   <= rk_d;
                    rcon_q <= xtime(rcon_q);
                    rcnt_q <= rcnt_q + 4'd1;
                    if (rcnt_q == ROUND_MAX) begin
                        load2_q    <= 1'b0;
                        round2_q   <= '0;
                        ct_valid_q <= 1'b1;
                        if (IDLE_ZERO) key2_q <= '0;
                        state_q    <= DONE;
                    end else begin
                        round2_q <= rcnt_q + 4'd1;
                        key2_q   <= rk_d;
                    end
                end
                DONE: begin
                    if (bus.ct_ready_i) begin
                        ct_valid_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AES_SEQ_TRIGGER_EN
    logic trig_q;

    // Rises with the accept edge, falls with the edge ending round 10.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else if (state_q == IDLE && bus.valid_i) begin
            trig_q <= 1'b1;
        end else if (state_q == ROUND && rcnt_q == ROUND_MAX) begin
            trig_q <= 1'b0;
        end
    end

    assign trig_o = trig_q;
`else
    assign trig_o = 1'b0;
`endif

    assign bus.ready_o    = ready_q;
    assign bus.ct_valid_o = ct_valid_q;
    assign bus.ct_o       = data_o;
    assign round1         = 4'd0;
    assign round2         = round2_q;
    assign round_max      = ROUND_MAX;
    assign load_i1        = load1_q;
    assign load_i2        = load2_q;
    assign key_i1         = key1_q;
    assign key_i2         = key2_q;
    // pt_q only changes on the accept edge, so this decode also gives the
    // hold-last-value behaviour when IDLE_ZERO is 0.
    assign data_i         = (IDLE_ZERO && !load1_q) ? '0 : pt_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RKB10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_sequencer_if bus ();
    logic         trig;
    logic [3:0]   round1, round2, round_max;
    logic         load_i1, load_i2;
    logic [127:0] key_i1, key_i2, data_i, data_o;

    aes_round_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .trig_o    (trig),
        .round1    (round1),
        .round2    (round2),
        .round_max (round_max),
        .load_i1   (load_i1),
        .load_i2   (load_i2),
        .key_i1    (key_i1),
        .key_i2    (key_i2),
        .data_i    (data_i),
        .data_o    (data_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AES reference functions (FIPS-197 word view) ----------------
    function automatic logic [7:0] mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [10:0][127:0] expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [10:0][127:0] rk;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {RCON[i/4], 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input bit last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = SBOX[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        if (last) begin
            b = t;
        end else begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                b[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
                b[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
                b[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
                b[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [10:0][127:0] rk);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
        return s;
    endfunction

    // ---------------- datapath stand-in: reacts to the DUT strobes ----------------
    logic [127:0] dp_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dp_q <= '0;
        else if (load_i1) dp_q <= data_i ^ key_i1;
        else if (load_i2) dp_q <= aes_round(dp_q, key_i2, round2 == round_max);
    end
    assign data_o = dp_q;

    // ---------------- expectation model: cycle index since accept ----------------
    // m_k = 0 idle, 1 = round-0 load, 2..11 = rounds 1..10, 12 = result waiting.
    int                 m_k = 0;
    logic [127:0]       m_pt;
    logic [10:0][127:0] m_rk;
    logic [127:0]       m_ct;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0;
        end else if (m_k == 0) begin
            if (bus.valid_i) begin
                m_k  <= 1;
                m_pt <= bus.pt_i;
                m_rk <= expand_key(bus.key_i);
                m_ct <= aes_encrypt(bus.pt_i, expand_key(bus.key_i));
            end
        end else if (m_k < 12) begin
            m_k <= m_k + 1;
        end else if (bus.ct_ready_i) begin
            m_k <= 0;
        end
    end

    always @(negedge clk) begin
        bit l1, l2, tg;
        if (started) begin
            l1 = (m_k == 1);
            l2 = (m_k >= 2 && m_k <= 11);
`ifdef AES_SEQ_TRIGGER_EN
            tg = (m_k >= 1 && m_k <= 11);
`else
            tg = 1'b0;
`endif
            chk("m_ready",     128'(bus.ready_o),    128'(m_k == 0));
            chk("m_ct_valid",  128'(bus.ct_valid_o), 128'(m_k >= 12));
            chk("m_load_i1",   128'(load_i1),        128'(l1));
            chk("m_load_i2",   128'(load_i2),        128'(l2));
            chk("m_round1",    128'(round1),         128'(0));
            chk("m_round2",    128'(round2),         l2 ? 128'(m_k - 1) : 128'(0));
            chk("m_round_max", 128'(round_max),      128'(10));
            chk("m_key_i1",    key_i1,               l1 ? m_rk[0] : 128'(0));
            chk("m_data_i",    data_i,               l1 ? m_pt : 128'(0));
            chk("m_key_i2",    key_i2,               l2 ? m_rk[m_k-1] : 128'(0));
            chk("m_trig",      128'(trig),           128'(tg));
            if (m_k >= 12) chk("m_ct", bus.ct_o, m_ct);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk_reset(input string tag);
        chk({tag, "_ready"},    128'(bus.ready_o),    128'(1));
        chk({tag, "_ct_valid"}, 128'(bus.ct_valid_o), 128'(0));
        chk({tag, "_load_i1"},  128'(load_i1),        128'(0));
        chk({tag, "_load_i2"},  128'(load_i2),        128'(0));
        chk({tag, "_round2"},   128'(round2),         128'(0));
        chk({tag, "_key_i1"},   key_i1,               128'(0));
        chk({tag, "_key_i2"},   key_i2,               128'(0));
        chk({tag, "_data_i"},   data_i,               128'(0));
        chk({tag, "_trig"},     128'(trig),           128'(0));
        chk({tag, "_round_max"}, 128'(round_max),     128'(10));
    endtask

    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp_ct, input int hold,
                             input bit chk_rk, input logic [127:0] exp_rk10);
        int n;
        int cyc;
        @(negedge clk);
        bus.valid_i = 1'b1; bus.pt_i = pt; bus.key_i = key; bus.ct_ready_i = 1'b0;
        n = 0;
        while (!bus.ready_o && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_accept_timeout"}, 128'(n < 50), 128'(1));
        @(negedge clk);
        cyc = 1;
        bus.valid_i = 1'b0;
        while (!bus.ct_valid_o && cyc < 40) begin
            if (chk_rk && cyc == 11) begin
                chk({tag, "_key_i2_round10"}, key_i2, exp_rk10);
                chk({tag, "_round2_is10"}, 128'(round2), 128'(10));
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 128'(cyc), 128'(12));
        chk({tag, "_ct"}, bus.ct_o, exp_ct);
        repeat (hold) begin
            chk({tag, "_bp_valid"}, 128'(bus.ct_valid_o), 128'(1));
            chk({tag, "_bp_ct"},    bus.ct_o,             exp_ct);
            chk({tag, "_bp_ready"}, 128'(bus.ready_o),    128'(0));
            @(negedge clk);
        end
        bus.ct_ready_i = 1'b1;
        @(negedge clk);
        bus.ct_ready_i = 1'b0;
        chk({tag, "_idle_ready"},    128'(bus.ready_o),    128'(1));
        chk({tag, "_idle_ct_valid"}, 128'(bus.ct_valid_o), 128'(0));
    endtask

    initial begin
        logic [10:0][127:0] rk_tmp;
        logic [127:0]       got [2];
        int cyc, t0, t1, nct;

        // Pin the reference model against FIPS-197 literals.
        rk_tmp = expand_key(KB);
        chk("model_rkB10", rk_tmp[10], RKB10);
        chk("model_ctB", aes_encrypt(PB, rk_tmp), CB);
        rk_tmp = expand_key(K1);
        chk("model_ct1", aes_encrypt(P1, rk_tmp), C1);

        rst_n = 1'b0;
        bus.valid_i = 1'b0; bus.ct_ready_i = 1'b0; bus.pt_i = '0; bus.key_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        started = 1'b1;

        // FIPS C.1 with 20 cycles of back-pressure.
        run_block("c1", P1, K1, C1, 20, 1'b0, 128'(0));
        // FIPS appendix B, round-10 key checked in its cycle.
        run_block("b", PB, KB, CB, 2, 1'b1, RKB10);

        // Back-to-back: valid held high, consumer always ready.
        @(negedge clk);
        bus.valid_i = 1'b1; bus.pt_i = P1; bus.key_i = K1; bus.ct_ready_i = 1'b1;
        cyc = 0; t0 = -1; t1 = -1; nct = 0;
        got[0] = '0; got[1] = '0;
        repeat (40) begin
            if (bus.ready_o) begin
                if (t0 < 0) t0 = cyc;
                else if (t1 < 0) t1 = cyc;
            end
            if (bus.ct_valid_o && nct < 2) begin got[nct] = bus.ct_o; nct++; end
            @(negedge clk);
            cyc++;
            if (t1 >= 0) bus.valid_i = 1'b0;
            else if (t0 >= 0) begin bus.pt_i = PB; bus.key_i = KB; end
        end
        bus.ct_ready_i = 1'b0;
        chk("b2b_spacing", 128'(t1 - t0), 128'(13));
        chk("b2b_count", 128'(nct), 128'(2));
        chk("b2b_ct0", got[0], C1);
        chk("b2b_ct1", got[1], CB);

        // Reset during round 5.
        @(negedge clk);
        bus.valid_i = 1'b1; bus.pt_i = PB; bus.key_i = KB;
        cyc = 0;
        while (!bus.ready_o && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_round2", 128'(round2), 128'(5));
        chk("mid_load_i2", 128'(load_i2), 128'(1));
        #1 rst_n = 1'b0;
        #1 chk_reset("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_block("after_rst", P1, K1, C1, 1, 1'b0, 128'(0));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
